// File: rtl/down_sample_multi_pkg.sv
// Shared definitions for the multi-mode decimator: reduction mode codes and
// width helpers used by the top level and the group reducer.
package down_sample_multi_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FIRST = 2'b00;
    localparam mode_t MODE_MEAN  = 2'b01;
    localparam mode_t MODE_MAX   = 2'b10;
    localparam mode_t MODE_MIN   = 2'b11;

    // One spare code above MAX_LOG2 so an out-of-range request can be seen and flagged.
    function automatic int ratio_sel_w(input int max_log2);
        return $clog2(max_log2 + 2);
    endfunction

    function automatic int cnt_w(input int max_log2);
        return (max_log2 > 0) ? max_log2 : 1;
    endfunction

endpackage

// File: rtl/down_sample_multi_reduce.sv
// Group reducer: keeps the running accumulator / extremum / first sample of the
// current group and presents the group result including the sample in flight.
module ds_group_reduce
    import down_sample_multi_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int MAX_LOG2 = 3,
    localparam int RW       = ratio_sel_w(MAX_LOG2),
    localparam int ACC_W    = DATA_W + MAX_LOG2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic                     first_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  mode_t                    mode_i,
    input  logic [RW-1:0]            k_i,
    output logic signed [DATA_W-1:0] reduced_o
);

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  upd;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] held;

    // For max/min/first the register holds a sign-extended sample, so one
    // register serves every mode; a mode change always restarts the group.
    always_comb begin
        sample_ext = ACC_W'(sample_i);
        held       = acc_q[DATA_W-1:0];
        upd        = acc_q;
        case (mode_i)
            MODE_MEAN: upd = first_i ? sample_ext : (acc_q + sample_ext);
            MODE_MAX:  if (first_i || (sample_i > held)) upd = sample_ext;
            MODE_MIN:  if (first_i || (sample_i < held)) upd = sample_ext;
            default:   if (first_i) upd = sample_ext;
        endcase
        shifted   = upd >>> k_i;
        reduced_o = (mode_i == MODE_MEAN) ? DATA_W'(shifted) : DATA_W'(upd);
        acc_d     = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = upd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/down_sample_multi.sv
// Run-time configurable decimator: every 2^k valid samples yield one output
// (first, mean, max or min of the group) one clock after the group closes.
module down_sample_multi
    import down_sample_multi_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int MAX_LOG2 = 3,
    localparam int RW       = ratio_sel_w(MAX_LOG2),
    localparam int CW       = cnt_w(MAX_LOG2)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic [RW-1:0]            i_log2_ratio,
    input  logic [1:0]               i_mode,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_cfg_err
);

    logic [RW-1:0]            k_in;
    logic [RW-1:0]            k_q;
    mode_t                    mode_q;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic [CW-1:0]            cnt_cur;
    logic [CW-1:0]            last_idx;
    logic                     bad_ratio;
    logic                     cfg_change;
    logic                     accept;
    logic                     first_s;
    logic                     last_s;
    logic                     red_clear;
    logic                     valid_q;
    logic                     valid_d;
    logic signed [DATA_W-1:0] data_q;
    logic signed [DATA_W-1:0] data_d;
    logic                     err_q;
    logic                     err_d;
    logic signed [DATA_W-1:0] reduced;

    // The incoming (clamped) config drives the datapath directly: it equals the
    // registered copy except in a change cycle, where the new config must apply.
    always_comb begin
        bad_ratio  = (i_log2_ratio > RW'(MAX_LOG2));
        k_in       = bad_ratio ? RW'(MAX_LOG2) : i_log2_ratio;
        cfg_change = (k_in != k_q) || (i_mode != mode_q);
        cnt_cur    = cfg_change ? '0 : cnt_q;
        last_idx   = '0;
        for (int i = 0; i < CW; i++) begin
            last_idx[i] = (i < int'(k_in));
        end
        accept    = i_valid && !i_clr;
        first_s   = (cnt_cur == '0);
        last_s    = (cnt_cur == last_idx);
        red_clear = i_clr || (cfg_change && !i_valid);
    end

    ds_group_reduce #(
        .DATA_W   (DATA_W),
        .MAX_LOG2 (MAX_LOG2)
    ) u_reduce (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .clear_i   (red_clear),
        .en_i      (accept),
        .first_i   (first_s),
        .sample_i  (i_data),
        .mode_i    (i_mode),
        .k_i       (k_in),
        .reduced_o (reduced)
    );

    // A clear or a config change drops any partial group before this cycle's sample counts.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || cfg_change) begin
            cnt_d = '0;
        end
        if (accept) begin
            cnt_d = last_s ? '0 : (cnt_cur + CW'(1));
        end
        valid_d = accept && last_s;
        data_d  = valid_d ? reduced : data_q;
        err_d   = i_clr ? 1'b0 : (err_q || bad_ratio);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            k_q     <= '0;
            mode_q  <= MODE_FIRST;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            k_q     <= k_in;
            mode_q  <= i_mode;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_cfg_err = err_q;

endmodule
